// File: rtl/hex_display_ctrl.sv
// Six-digit scanned hex display controller: one shared decoder refreshes one registered
// digit output per cycle, with per-digit enable and blink masks and a digit-write error flag.
module hex_display_ctrl #(
  parameter int unsigned BLINK_HALF = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [2:0] wr_addr,
  input  logic [5:0] wr_data,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [2:0] scan_idx,
  output logic       wr_err
);

  localparam int unsigned CntW = 25;
  localparam logic [CntW-1:0] BlinkLast = CntW'(BLINK_HALF - 1);
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [2:0] LastSlot = 3'd5;

  typedef enum logic [1:0] {
    CmdDigit  = 2'b00,
    CmdEnable = 2'b01,
    CmdBlink  = 2'b10,
    CmdClear  = 2'b11
  } cmd_e;

  logic [3:0]      digit_q [6];
  logic [3:0]      digit_d [6];
  logic [5:0]      en_mask_q, en_mask_d;
  logic [5:0]      blink_mask_q, blink_mask_d;
  logic            wr_err_q, wr_err_d;
  logic [2:0]      scan_q, scan_d;
  logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [6:0]      hex_q [6];
  logic [3:0]      digit_sel;
  logic            blank;
  logic [6:0]      seg_d;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] val);
    logic [6:0] seg;
    unique case (val)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // The single decoder sees only the digit in the current scan slot, taken from the
  // pre-write state so a same-cycle write shows up on the next visit.
  always_comb begin
    digit_sel = digit_q[scan_q];
    blank     = !en_mask_q[scan_q] || (blink_mask_q[scan_q] && blink_phase_q);
    seg_d     = blank ? SegBlank : decode(digit_sel);
  end

  always_comb begin
    scan_d = (scan_q == LastSlot) ? 3'd0 : scan_q + 3'd1;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d   = '0;
      blink_phase_d = !blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + 1'b1;
      blink_phase_d = blink_phase_q;
    end
  end

  always_comb begin
    digit_d      = digit_q;
    en_mask_d    = en_mask_q;
    blink_mask_d = blink_mask_q;
    wr_err_d     = wr_err_q;
    if (wr_en) begin
      unique case (cmd_e'(wr_sel))
        CmdDigit: begin
          if (wr_addr <= LastSlot) begin
            digit_d[wr_addr] = wr_data[3:0];
          end else begin
            wr_err_d = 1'b1;
          end
        end
        CmdEnable: en_mask_d    = wr_data;
        CmdBlink:  blink_mask_d = wr_data;
        CmdClear: begin
          for (int i = 0; i < 6; i++) begin
            digit_d[i] = 4'h0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        digit_q[i] <= 4'h0;
        hex_q[i]   <= SegBlank;
      end
      en_mask_q     <= '0;
      blink_mask_q  <= '0;
      wr_err_q      <= 1'b0;
      scan_q        <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      digit_q        <= digit_d;
      hex_q[scan_q]  <= seg_d;
      en_mask_q      <= en_mask_d;
      blink_mask_q   <= blink_mask_d;
      wr_err_q       <= wr_err_d;
      scan_q         <= scan_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
    end
  end

  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];
  assign scan_idx = scan_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed vector table, multi-cycle corner sequences and
// randomized commands checked against a cycle-count based reference model.
module tb_hex_display_ctrl;

  localparam int unsigned BlinkHalf = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;
  logic [6:0] hex [6];
  logic [2:0] scan_idx;
  logic       wr_err;

  hex_display_ctrl #(.BLINK_HALF(BlinkHalf)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .hex0    (hex[0]),
    .hex1    (hex[1]),
    .hex2    (hex[2]),
    .hex3    (hex[3]),
    .hex4    (hex[4]),
    .hex5    (hex[5]),
    .scan_idx(scan_idx),
    .wr_err  (wr_err)
  );

  always #5 clk = !clk;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: scan slot and blink phase follow from the cycle count t since reset.
  int         n_vec = 0;
  int         n_bad = 0;
  int         t;
  logic [3:0] m_dig [6];
  logic [5:0] m_en, m_bl;
  logic       m_err;
  logic [6:0] m_hex [6];

  typedef struct {
    logic [2:0] addr;
    logic [3:0] val;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_dig[i] = 4'h0;
      m_hex[i] = 7'h7F;
    end
    m_en  = '0;
    m_bl  = '0;
    m_err = 1'b0;
    t     = 0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 6; i++) check($sformatf("%s_hex%0d", tag, i), 32'(hex[i]), 32'(m_hex[i]));
    check({tag, "_scan"}, 32'(scan_idx), 32'(t % 6));
    check({tag, "_err"}, 32'(wr_err), 32'(m_err));
  endtask

  task automatic step();
    int k;
    int ph;
    @(posedge clk);
    k  = t % 6;
    ph = (t / BlinkHalf) % 2;
    if (!m_en[k] || (m_bl[k] && ph == 1)) m_hex[k] = 7'h7F;
    else m_hex[k] = seg_tbl[m_dig[k]];
    if (wr_en) begin
      case (wr_sel)
        2'b00: if (wr_addr < 3'd6) m_dig[wr_addr] = wr_data[3:0]; else m_err = 1'b1;
        2'b01: m_en = wr_data;
        2'b10: m_bl = wr_data;
        default: for (int i = 0; i < 6; i++) m_dig[i] = 4'h0;
      endcase
    end
    t++;
    #1;
    check_all("step");
  endtask

  task automatic cmd(input logic [1:0] sel, input logic [2:0] addr, input logic [5:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_slot(input logic [2:0] slot);
    int budget = 12;
    while (scan_idx != slot && budget > 0) begin
      step();
      budget--;
    end
    check("wait_slot", 32'(scan_idx), 32'(slot));
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge, and a command
  // presented during reset must be ignored.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    wr_en   = 1'b1;
    wr_sel  = 2'($urandom_range(0, 3));
    wr_addr = 3'($urandom_range(0, 7));
    wr_data = 6'($urandom_range(0, 63));
    repeat (2) @(posedge clk);
    #1;
    check_all("inrst");
    rst_n = 1'b1;
    wr_en = 1'b0;
  endtask

  initial begin
    logic seen_on;
    logic seen_off;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = '0;
    wr_addr = '0;
    wr_data = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) vecs[i] = '{3'(i % 6), 4'(i), seg_tbl[i]};
    vecs[16] = '{3'd0, 4'h0, 7'h40};
    vecs[17] = '{3'd1, 4'h1, 7'h79};
    vecs[18] = '{3'd2, 4'h2, 7'h24};
    vecs[19] = '{3'd3, 4'h3, 7'h30};
    vecs[20] = '{3'd4, 4'h4, 7'h19};
    vecs[21] = '{3'd5, 4'h5, 7'h12};

    cmd(2'b01, 3'd0, 6'h3F);
    for (int i = 0; i < 22; i++) begin
      cmd(2'b00, vecs[i].addr, 6'(vecs[i].val));
      idle(6);
      check($sformatf("vec%0d", i), 32'(hex[vecs[i].addr]), 32'(vecs[i].exp));
    end

    // Write during the scan of the same slot: old value for this visit, new on the next.
    wait_slot(3'd3);
    cmd(2'b00, 3'd3, 6'h0B);
    check("same_slot_old", 32'(hex[3]), 32'h30);
    idle(5);
    check("same_slot_hold", 32'(hex[3]), 32'h30);
    idle(1);
    check("same_slot_new", 32'(hex[3]), 32'h03);

    wait_slot(3'd4);
    async_reset();
    step();
    check("post_rst_scan", 32'(scan_idx), 32'd1);
    check("post_rst_hex0", 32'(hex[0]), 32'h7F);

    cmd(2'b01, 3'd0, 6'h3F);
    cmd(2'b10, 3'd0, 6'h01);
    cmd(2'b00, 3'd0, 6'h08);
    seen_on  = 1'b0;
    seen_off = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (i >= 6 && hex[0] == 7'h00) seen_on = 1'b1;
      if (i >= 6 && hex[0] == 7'h7F) seen_off = 1'b1;
    end
    check("blink_on_seen", 32'(seen_on), 32'd1);
    check("blink_off_seen", 32'(seen_off), 32'd1);
    check("blink_hex1", 32'(hex[1]), 32'h40);

    cmd(2'b00, 3'd6, 6'h07);
    check("err_set", 32'(wr_err), 32'd1);
    idle(20);
    check("err_sticky", 32'(wr_err), 32'd1);

    cmd(2'b10, 3'd0, 6'h00);
    cmd(2'b11, 3'd0, 6'h00);
    idle(6);
    for (int i = 0; i < 6; i++) check($sformatf("clear_hex%0d", i), 32'(hex[i]), 32'h40);
    cmd(2'b01, 3'd0, 6'h00);
    idle(6);
    for (int i = 0; i < 6; i++) check($sformatf("off_hex%0d", i), 32'(hex[i]), 32'h7F);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_sel  = 2'($urandom_range(0, 3));
      wr_addr = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      wr_data = 6'($urandom_range(0, 63));
      step();
    end
    wr_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
